// File: rtl/connect4_pkg.sv
// Shared types and defaults for the Connect-4 board-state block.
package connect4_pkg;

  localparam int DEF_COLS    = 7;
  localparam int DEF_ROWS    = 6;
  localparam int DEF_WIN_LEN = 4;

  typedef enum logic [1:0] {
    IDLE,
    PLACE,
    CHECK,
    GAME_OVER
  } state_t;

  typedef enum logic {
    PLAYER_RED   = 1'b0,
    PLAYER_GREEN = 1'b1
  } player_t;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_RED   = 2'b01,
    WIN_GREEN = 2'b10,
    WIN_DRAW  = 2'b11
  } winner_t;

endpackage

// File: rtl/connect4_board_state_if.sv
// Request/status bundle between the column-select stage, the board state
// block and the LED-matrix / display consumers.
interface connect4_board_state_if
  import connect4_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
);

  logic [COLS-1:0]      column_select;
  logic                 new_game;
  logic [COLS*ROWS-1:0] red_board;
  logic [COLS*ROWS-1:0] green_board;
  logic                 current_player;
  logic                 move_accepted;
  logic                 move_rejected;
  logic                 game_over;
  logic [1:0]           winner;

  modport master (
    output column_select, new_game,
    input  red_board, green_board, current_player,
    input  move_accepted, move_rejected, game_over, winner
  );

  modport slave (
    input  column_select, new_game,
    output red_board, green_board, current_player,
    output move_accepted, move_rejected, game_over, winner
  );

endinterface

// File: rtl/connect4_win_check.sv
// Combinational WIN_LEN-in-a-row detector for one player's occupancy map.
// Every cell is tried as the start of a window in each of four directions
// (right, up, up-right, up-left); windows that run off the board are tied off.
module connect4_win_check
  import connect4_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS,
  parameter int WIN_LEN = DEF_WIN_LEN
) (
  input  logic [COLS*ROWS-1:0] board,
  output logic                 win
);

  localparam int CELLS = COLS * ROWS;

  logic [4*CELLS-1:0] hits;

  for (genvar gd = 0; gd < 4; gd++) begin : g_dir
    // Direction step: 0 = horizontal, 1 = vertical, 2 = up-right, 3 = up-left
    localparam int DR = (gd == 0) ? 0 : 1;
    localparam int DC = (gd == 1) ? 0 : ((gd == 3) ? -1 : 1);
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      for (genvar gj = 0; gj < COLS; gj++) begin : g_col
        localparam int END_R = gi + (WIN_LEN - 1) * DR;
        localparam int END_C = gj + (WIN_LEN - 1) * DC;
        localparam int HIT   = gd * CELLS + gi * COLS + gj;
        if (END_R < ROWS && END_C >= 0 && END_C < COLS) begin : g_win
          logic [WIN_LEN-1:0] cells;
          for (genvar gk = 0; gk < WIN_LEN; gk++) begin : g_cell
            localparam int IDX = (gi + gk * DR) * COLS + gj + gk * DC;
            assign cells[gk] = board[IDX];
          end
          assign hits[HIT] = &cells;
        end else begin : g_none
          assign hits[HIT] = 1'b0;
        end
      end
    end
  end

  assign win = |hits;

endmodule

// File: rtl/connect4_board_state.sv
// Connect-4 board state: turns a one-hot column request into a piece drop,
// checks for a win or a full board, and alternates turns.
module connect4_board_state
  import connect4_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS,
  parameter int WIN_LEN = DEF_WIN_LEN
) (
  input  logic                   clk,
  input  logic                   reset,
  connect4_board_state_if.slave  bus
);

  localparam int CELLS = COLS * ROWS;
  localparam int HW    = $clog2(ROWS + 1);
  localparam int CW    = $clog2(CELLS + 1);
  localparam int XW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [CELLS-1:0] ONE_CELL = 1;

  state_t                  state_reg, state_next;
  logic [COLS-1:0]         prev_sel_reg;
  logic [CELLS-1:0]        red_reg, red_next;
  logic [CELLS-1:0]        green_reg, green_next;
  logic [COLS-1:0][HW-1:0] height_reg, height_next;
  logic [CW-1:0]           count_reg, count_next;
  logic [XW-1:0]           col_reg, col_next;
  player_t                 player_reg, player_next;
  winner_t                 winner_reg, winner_next;
  logic                    game_over_reg, game_over_next;
  logic                    accepted_reg, accepted_next;
  logic                    rejected_reg, rejected_next;

  logic                    request;
  logic                    one_hot;
  logic [XW-1:0]           sel_col;
  logic [HW-1:0]           cur_height;
  logic [IW-1:0]           place_idx;
  logic [CELLS-1:0]        place_mask;
  logic [CELLS-1:0]        check_board;
  logic                    win;

  // A request is the rising edge of "any column selected"; holding enter is one request
  assign request    = (prev_sel_reg == '0) && (bus.column_select != '0);
  assign one_hot    = (bus.column_select & (bus.column_select - COLS'(1))) == '0;
  assign cur_height = height_reg[col_reg];
  assign place_idx  = IW'(cur_height) * IW'(COLS) + IW'(col_reg);
  assign place_mask = ONE_CELL << place_idx;
  assign check_board = (player_reg == PLAYER_GREEN) ? green_reg : red_reg;

  // Encode the selected column; only meaningful when one_hot is set
  always_comb begin
    sel_col = '0;
    for (int i = 0; i < COLS; i++) begin
      if (bus.column_select[i]) begin
        sel_col = XW'(i);
      end
    end
  end

  connect4_win_check #(
    .COLS    (COLS),
    .ROWS    (ROWS),
    .WIN_LEN (WIN_LEN)
  ) u_win_check (
    .board (check_board),
    .win   (win)
  );

  // Next-state and datapath updates; new_game overrides everything else
  always_comb begin
    state_next     = state_reg;
    red_next       = red_reg;
    green_next     = green_reg;
    height_next    = height_reg;
    count_next     = count_reg;
    col_next       = col_reg;
    player_next    = player_reg;
    winner_next    = winner_reg;
    game_over_next = game_over_reg;
    accepted_next  = 1'b0;
    rejected_next  = 1'b0;

    if (bus.new_game) begin
      state_next     = IDLE;
      red_next       = '0;
      green_next     = '0;
      height_next    = '0;
      count_next     = '0;
      player_next    = PLAYER_RED;
      winner_next    = WIN_NONE;
      game_over_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (request) begin
            if (!one_hot || height_reg[sel_col] >= HW'(ROWS)) begin
              rejected_next = 1'b1;
            end else begin
              col_next   = sel_col;
              state_next = PLACE;
            end
          end
        end
        PLACE: begin
          if (player_reg == PLAYER_GREEN) begin
            green_next = green_reg | place_mask;
          end else begin
            red_next = red_reg | place_mask;
          end
          height_next[col_reg] = (cur_height == HW'(ROWS)) ? cur_height : cur_height + HW'(1);
          count_next    = count_reg + CW'(1);
          accepted_next = 1'b1;
          state_next    = CHECK;
        end
        CHECK: begin
          if (win) begin
            winner_next    = (player_reg == PLAYER_GREEN) ? WIN_GREEN : WIN_RED;
            game_over_next = 1'b1;
            state_next     = GAME_OVER;
          end else if (count_reg == CW'(CELLS)) begin
            winner_next    = WIN_DRAW;
            game_over_next = 1'b1;
            state_next     = GAME_OVER;
          end else begin
            player_next = (player_reg == PLAYER_RED) ? PLAYER_GREEN : PLAYER_RED;
            state_next  = IDLE;
          end
        end
        GAME_OVER: begin
          state_next = GAME_OVER;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State register; reset drops any in-flight placement
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      prev_sel_reg  <= '0;
      red_reg       <= '0;
      green_reg     <= '0;
      height_reg    <= '0;
      count_reg     <= '0;
      col_reg       <= '0;
      player_reg    <= PLAYER_RED;
      winner_reg    <= WIN_NONE;
      game_over_reg <= 1'b0;
      accepted_reg  <= 1'b0;
      rejected_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prev_sel_reg  <= bus.column_select;
      red_reg       <= red_next;
      green_reg     <= green_next;
      height_reg    <= height_next;
      count_reg     <= count_next;
      col_reg       <= col_next;
      player_reg    <= player_next;
      winner_reg    <= winner_next;
      game_over_reg <= game_over_next;
      accepted_reg  <= accepted_next;
      rejected_reg  <= rejected_next;
    end
  end

  assign bus.red_board      = red_reg;
  assign bus.green_board    = green_reg;
  assign bus.current_player = player_reg;
  assign bus.winner         = winner_reg;
  assign bus.game_over      = game_over_reg;
  assign bus.move_accepted  = accepted_reg;
  assign bus.move_rejected  = rejected_reg;

endmodule

// File: tb/tb_connect4_board_state.sv
// Directed bench for connect4_board_state: a move table plus hand sequences
// for reset-during-PLACE and a full-board draw.
module tb_connect4_board_state;

  typedef struct {
    logic [6:0] sel;
    logic       ng;
    int         pulse;  // 0 none, 1 accepted, 2 rejected
    int         rbit;   // red board bit expected set, -1 none
    int         gbit;   // green board bit expected set, -1 none
    logic       pl;
    logic [1:0] win;
    logic       go;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   pieces_exp;

  connect4_board_state_if #(.COLS(7), .ROWS(6)) bus ();

  connect4_board_state #(.COLS(7), .ROWS(6), .WIN_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] sel, input logic ng, input int pulse,
                              input int rbit, input int gbit, input logic pl,
                              input logic [1:0] win, input logic go);
    vec_t v;
    v.sel = sel; v.ng = ng; v.pulse = pulse; v.rbit = rbit; v.gbit = gbit;
    v.pl = pl; v.win = win; v.go = go;
    return v;
  endfunction

  // Hold the request for five edges, release, then check pulses and final status
  task automatic apply(input vec_t v, input string tag);
    int acc_cnt;
    int rej_cnt;
    acc_cnt = 0;
    rej_cnt = 0;
    @(negedge clk);
    bus.column_select = v.sel;
    bus.new_game      = v.ng;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      bus.new_game = 1'b0;
      acc_cnt += int'(bus.move_accepted);
      rej_cnt += int'(bus.move_rejected);
      if (k == 4) bus.column_select = '0;
    end
    if (v.ng) pieces_exp = 0;
    if (v.pulse == 1) pieces_exp++;
    chk({tag, "_acc"}, 64'(acc_cnt), (v.pulse == 1) ? 64'd1 : 64'd0);
    chk({tag, "_rej"}, 64'(rej_cnt), (v.pulse == 2) ? 64'd1 : 64'd0);
    chk({tag, "_player"}, 64'(bus.current_player), 64'(v.pl));
    chk({tag, "_winner"}, 64'(bus.winner), 64'(v.win));
    chk({tag, "_gameover"}, 64'(bus.game_over), 64'(v.go));
    chk({tag, "_pieces"}, 64'($countones(bus.red_board | bus.green_board)), 64'(pieces_exp));
    if (v.rbit >= 0) chk({tag, "_redbit"}, 64'(bus.red_board[v.rbit]), 64'd1);
    if (v.gbit >= 0) chk({tag, "_greenbit"}, 64'(bus.green_board[v.gbit]), 64'd1);
    $display("move %s sel=%b acc=%0d rej=%0d player=%0d winner=%b go=%0d", tag, v.sel,
             acc_cnt, rej_cnt, bus.current_player, bus.winner, bus.game_over);
  endtask

  vec_t vecs[31];
  int   draw_cols[42] = '{0,1,0,1,1,0,1,0,0,1,1,0,
                          2,3,2,3,3,2,3,2,2,3,3,2,
                          4,5,6,5,4,4,6,4,5,6,5,6,4,4,6,5,5,6};

  initial begin
    checks = 0;
    errors = 0;
    pieces_exp = 0;

    // Single red move held for several cycles
    vecs[0]  = mk(7'b0000001, 1'b0, 1, 0, -1, 1'b1, 2'b00, 1'b0);
    vecs[1]  = mk(7'b0000000, 1'b1, 0, -1, -1, 1'b0, 2'b00, 1'b0);
    // Vertical red win in column 3 against green in column 4
    vecs[2]  = mk(7'b0001000, 1'b0, 1, 3, -1, 1'b1, 2'b00, 1'b0);
    vecs[3]  = mk(7'b0010000, 1'b0, 1, -1, 4, 1'b0, 2'b00, 1'b0);
    vecs[4]  = mk(7'b0001000, 1'b0, 1, 10, -1, 1'b1, 2'b00, 1'b0);
    vecs[5]  = mk(7'b0010000, 1'b0, 1, -1, 11, 1'b0, 2'b00, 1'b0);
    vecs[6]  = mk(7'b0001000, 1'b0, 1, 17, -1, 1'b1, 2'b00, 1'b0);
    vecs[7]  = mk(7'b0010000, 1'b0, 1, -1, 18, 1'b0, 2'b00, 1'b0);
    vecs[8]  = mk(7'b0001000, 1'b0, 1, 24, -1, 1'b0, 2'b01, 1'b1);
    vecs[9]  = mk(7'b0100000, 1'b0, 0, -1, -1, 1'b0, 2'b01, 1'b1);
    vecs[10] = mk(7'b0000000, 1'b1, 0, -1, -1, 1'b0, 2'b00, 1'b0);
    // Fill column 0, then overfill and multi-hot requests
    vecs[11] = mk(7'b0000001, 1'b0, 1, 0, -1, 1'b1, 2'b00, 1'b0);
    vecs[12] = mk(7'b0000001, 1'b0, 1, -1, 7, 1'b0, 2'b00, 1'b0);
    vecs[13] = mk(7'b0000001, 1'b0, 1, 14, -1, 1'b1, 2'b00, 1'b0);
    vecs[14] = mk(7'b0000001, 1'b0, 1, -1, 21, 1'b0, 2'b00, 1'b0);
    vecs[15] = mk(7'b0000001, 1'b0, 1, 28, -1, 1'b1, 2'b00, 1'b0);
    vecs[16] = mk(7'b0000001, 1'b0, 1, -1, 35, 1'b0, 2'b00, 1'b0);
    vecs[17] = mk(7'b0000001, 1'b0, 2, -1, -1, 1'b0, 2'b00, 1'b0);
    vecs[18] = mk(7'b0010100, 1'b0, 2, -1, -1, 1'b0, 2'b00, 1'b0);
    vecs[19] = mk(7'b0000000, 1'b1, 0, -1, -1, 1'b0, 2'b00, 1'b0);
    // Green diagonal (0,0),(1,1),(2,2),(3,3)
    vecs[20] = mk(7'b0000010, 1'b0, 1, 1, -1, 1'b1, 2'b00, 1'b0);
    vecs[21] = mk(7'b0000001, 1'b0, 1, -1, 0, 1'b0, 2'b00, 1'b0);
    vecs[22] = mk(7'b0000100, 1'b0, 1, 2, -1, 1'b1, 2'b00, 1'b0);
    vecs[23] = mk(7'b0000010, 1'b0, 1, -1, 8, 1'b0, 2'b00, 1'b0);
    vecs[24] = mk(7'b0001000, 1'b0, 1, 3, -1, 1'b1, 2'b00, 1'b0);
    vecs[25] = mk(7'b0000100, 1'b0, 1, -1, 9, 1'b0, 2'b00, 1'b0);
    vecs[26] = mk(7'b0001000, 1'b0, 1, 10, -1, 1'b1, 2'b00, 1'b0);
    vecs[27] = mk(7'b0000100, 1'b0, 1, -1, 16, 1'b0, 2'b00, 1'b0);
    vecs[28] = mk(7'b0001000, 1'b0, 1, 17, -1, 1'b1, 2'b00, 1'b0);
    vecs[29] = mk(7'b0001000, 1'b0, 1, -1, 24, 1'b1, 2'b10, 1'b1);
    vecs[30] = mk(7'b0000000, 1'b1, 0, -1, -1, 1'b0, 2'b00, 1'b0);

    // Reset state
    reset = 1'b0;
    bus.column_select = '0;
    bus.new_game = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_red", 64'(bus.red_board), 64'd0);
    chk("rst_green", 64'(bus.green_board), 64'd0);
    chk("rst_player", 64'(bus.current_player), 64'd0);
    chk("rst_winner", 64'(bus.winner), 64'd0);
    chk("rst_gameover", 64'(bus.game_over), 64'd0);
    chk("rst_pulses", 64'({bus.move_accepted, bus.move_rejected}), 64'd0);
    $display("reset state red=%0h green=%0h", bus.red_board, bus.green_board);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 31; i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
      if (i == 9) begin
        chk("colwin_red", 64'(bus.red_board), 64'h1020408);
        chk("colwin_green", 64'(bus.green_board), 64'h40810);
      end
      if (i == 18) begin
        chk("fullcol_red", 64'(bus.red_board), 64'h10004001);
        chk("fullcol_green", 64'(bus.green_board), 64'h800200080);
      end
      if (i == 29) begin
        chk("diag_red", 64'(bus.red_board), 64'h2040E);
        chk("diag_green", 64'(bus.green_board), 64'h1010301);
      end
      if (i == 30) begin
        chk("newgame_red", 64'(bus.red_board), 64'd0);
        chk("newgame_green", 64'(bus.green_board), 64'd0);
      end
    end

    // Reset asserted while a second move is in PLACE
    apply(mk(7'b0000100, 1'b0, 1, 2, -1, 1'b1, 2'b00, 1'b0), "pre_rst");
    @(negedge clk);
    bus.column_select = 7'b0000100;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_red", 64'(bus.red_board), 64'd0);
    chk("midrst_green", 64'(bus.green_board), 64'd0);
    chk("midrst_player", 64'(bus.current_player), 64'd0);
    chk("midrst_winner", 64'(bus.winner), 64'd0);
    chk("midrst_gameover", 64'(bus.game_over), 64'd0);
    chk("midrst_pulses", 64'({bus.move_accepted, bus.move_rejected}), 64'd0);
    $display("reset during PLACE red=%0h green=%0h", bus.red_board, bus.green_board);
    @(negedge clk);
    bus.column_select = '0;
    @(negedge clk);
    reset = 1'b1;
    pieces_exp = 0;
    apply(mk(7'b0000100, 1'b0, 1, 2, -1, 1'b1, 2'b00, 1'b0), "post_rst");

    // Full-board draw
    apply(mk(7'b0000000, 1'b1, 0, -1, -1, 1'b0, 2'b00, 1'b0), "draw_ng");
    for (int m = 0; m < 42; m++) begin
      logic [6:0] s;
      logic       pl;
      s  = 7'b0000001 << draw_cols[m];
      pl = (m == 41) ? 1'b1 : ((m % 2) == 0);
      apply(mk(s, 1'b0, 1, -1, -1, pl, (m == 41) ? 2'b11 : 2'b00, (m == 41)),
            $sformatf("draw%0d", m));
    end
    apply(mk(7'b0000001, 1'b0, 0, -1, -1, 1'b1, 2'b11, 1'b1), "draw_after");
    chk("draw_full", 64'(bus.red_board | bus.green_board), 64'h3FFFFFFFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
